kc85_modbus_ctl: RTL and testbench
==================================

# kc85_modbus_ctl

Host-side controller for the KC85 module bus. It issues the Z80-style I/O cycles that expansion modules such as the M062 respond to: control-byte writes (OUT to port `{slot,80h}`) and module-ID reads (IN from `{slot,80h}`). It sits between the system-side configuration logic and the module slot connector. It generates IORQ/RD/WR strobes with Z80 T-state timing, honours WAIT, and aborts on a stuck WAIT.

## Interface
Parameters:
- `WAIT_MAX`, default 16: maximum number of TW cycles per access before timeout; must be ≥ 1.

Ports:
- `CLK`  in  1  single system clock; all state changes occur on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `REQ`  in  1  start request; sampled only while `BUSY`=0.
- `OP`  in  1  0 = ID read, 1 = control write; sampled with `REQ`.
- `SLOT`  in  8  module slot address; becomes A[15:8]; sampled with `REQ`.
- `WDATA`  in  8  control byte for writes; sampled with `REQ`.
- `BUSY`  out  1  access in progress (states T1..T3).
- `DONE`  out  1  one-cycle pulse on completion or timeout.
- `ERR`  out  1  valid only with `DONE`; 1 = timeout.
- `RDATA`  out  8  last ID byte read.
- `A`  out  16  bus address.
- `D_OUT`  out  8  bus write data.
- `D_OE`  out  1  data bus output enable.
- `D_IN`  in  8  bus read data.
- `IORQ_N`  out  1  I/O request, active low.
- `RD_N`  out  1  read strobe, active low.
- `WR_N`  out  1  write strobe, active low.
- `WAIT_N`  in  1  wait request from module, active low; synchronous to `CLK`.

## Operation
- States: IDLE, T1, T2, TW, T3. All outputs are registered.
- IDLE:
  - `REQ`=1 latches `OP`, `SLOT` and `WDATA`, then moves to T1.
  - Otherwise stays in IDLE.
- T1:
  - `A` = {SLOT, 8'h80}.
  - Strobes inactive.
  - For a write, `D_OUT` = WDATA and `D_OE`=1.
- T2:
  - `IORQ_N`=0.
  - Read: `RD_N`=0. Write: `WR_N`=0.
  - `A`, `D_OUT` and `D_OE` held.
- TW: the first TW is mandatory (Z80 automatic I/O wait).
  - At the end of each TW, `WAIT_N`=1 moves to T3.
  - At the end of each TW, `WAIT_N`=0 stays in TW and increments the wait counter.
  - When the counter reaches `WAIT_MAX` with `WAIT_N` still 0, go to IDLE with the timeout outcome.
- T3:
  - Strobes still asserted.
  - At the edge leaving T3, a read captures `D_IN` into `RDATA`.
  - All strobes go to 1 and `D_OE` goes to 0 at that edge. Go to IDLE.
- Completion:
  - In the first IDLE cycle after T3: `DONE`=1, `ERR`=0.
  - On timeout: `DONE`=1, `ERR`=1, strobes released in that same cycle, and `RDATA` forced to 8'hFF for reads (unchanged for writes).
- `A` holds its last value in IDLE. `D_OUT` holds its last value; `D_OE`=0.
- `REQ` while `BUSY`=1 is ignored; there is no queueing.
- Back-to-back: a `REQ` in the `DONE` cycle is accepted, since `BUSY`=0 there.
- Reset values: `A`=0, `D_OUT`=0, `D_OE`=0, `IORQ_N`=`RD_N`=`WR_N`=1, `BUSY`=0, `DONE`=0, `ERR`=0, `RDATA`=0, state IDLE, wait counter 0.
- `RESET` asserted mid-access:
  - Strobes deassert immediately (asynchronously), `D_OE`=0.
  - No `DONE` pulse follows.

## Timing
- `REQ` sampled at edge k gives: T1 in cycle k+1, T2 in k+2, TW in k+3, T3 in k+4, and `DONE` in k+5 (no extra waits).
- Each additional `WAIT_N`=0 sample adds exactly one TW cycle.
- `IORQ_N` low duration = 3 + n cycles, where n = number of extra waits.
- A write holds `D_OE`=1 from T1 through T3: 4 + n cycles.
- `A` is stable from T1 through the `DONE` cycle.
- Timeout: `DONE` occurs `WAIT_MAX` TW cycles after T2, i.e. k+3+`WAIT_MAX`.
- Minimum spacing between successive T1 states is 5 cycles.

## Test plan
- Control write, `SLOT`=8'h08, `WDATA`=8'h41, `WAIT_N`=1 → `A`=16'h0880 from k+1; `WR_N` low k+2..k+4; `D_OUT`=8'h41 with `D_OE`=1 k+1..k+4; `RD_N` stays 1; `DONE`=1, `ERR`=0 at k+5.
- ID read, `SLOT`=8'h0C, `D_IN`=8'hF7 → `A`=16'h0C80; `RD_N` low k+2..k+4; `D_OE`=0 throughout; `RDATA`=8'hF7 at k+5.
- Read with `WAIT_N` held 0 for 3 TW samples → 4 TW cycles total; `IORQ_N` low 6 cycles; `DONE` at k+8.
- `WAIT_N` stuck 0, `WAIT_MAX`=16 → strobes release and `DONE`=1, `ERR`=1 at k+19; `RDATA`=8'hFF; a new `REQ` is then accepted normally.
- `REQ` held continuously high with alternating `OP` → accesses start every 5 cycles; `REQ` during `BUSY` does not alter the latched `SLOT`/`WDATA`.
- `RESET` pulsed during T2 of a write → `WR_N`, `IORQ_N`=1 and `D_OE`=0 before the next `CLK` edge; no `DONE`; all outputs at reset values.

Source files
------------

// File: rtl/kc85_modbus_ctl.sv
// KC85 module-bus host controller: issues Z80-style I/O cycles (control OUT and
// module-ID IN at port {slot,80h}) with T-state strobe timing, WAIT and timeout.
module kc85_modbus_ctl #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        OP,
    input  logic [7:0]  SLOT,
    input  logic [7:0]  WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [7:0]  RDATA,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    output logic        IORQ_N,
    output logic        RD_N,
    output logic        WR_N,
    input  logic        WAIT_N
);

    // The counter only has to reach WAIT_MAX-1: the final TW sample decides the timeout.
    localparam int unsigned   CW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3
    } state_t;

    state_t        state;
    logic          op_wr;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            op_wr    <= 1'b0;
            wait_cnt <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            RDATA    <= '0;
            A        <= '0;
            D_OUT    <= '0;
            D_OE     <= 1'b0;
            IORQ_N   <= 1'b1;
            RD_N     <= 1'b1;
            WR_N     <= 1'b1;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (REQ) begin
                        state <= T1;
                        op_wr <= OP;
                        BUSY  <= 1'b1;
                        A     <= {SLOT, 8'h80};
                        if (OP) begin
                            D_OUT <= WDATA;
                            D_OE  <= 1'b1;
                        end
                    end
                end
                T1: begin
                    state  <= T2;
                    IORQ_N <= 1'b0;
                    if (op_wr) WR_N <= 1'b0;
                    else       RD_N <= 1'b0;
                end
                T2: begin
                    state    <= TW;
                    wait_cnt <= '0;
                end
                TW: begin
                    if (WAIT_N) begin
                        state <= T3;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Stuck WAIT: abandon the cycle and report the timeout.
                        state  <= IDLE;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        ERR    <= 1'b1;
                        IORQ_N <= 1'b1;
                        RD_N   <= 1'b1;
                        WR_N   <= 1'b1;
                        D_OE   <= 1'b0;
                        if (!op_wr) RDATA <= 8'hFF;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                T3: begin
                    state  <= IDLE;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b1;
                    IORQ_N <= 1'b1;
                    RD_N   <= 1'b1;
                    WR_N   <= 1'b1;
                    D_OE   <= 1'b0;
                    if (!op_wr) RDATA <= D_IN;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kc85_modbus_ctl.sv
// Bench for kc85_modbus_ctl: transaction-level timing model checked every cycle,
// plus literal spot checks of the directed scenarios.
module tb_kc85_modbus_ctl;

    localparam int WAIT_MAX = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        op = 1'b0;
    logic [7:0]  slot = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  d_in = '0;
    logic        wait_n = 1'b1;
    logic        busy, done, err, d_oe, iorq_n, rd_n, wr_n;
    logic [7:0]  rdata, d_out;
    logic [15:0] a;

    int n_checks = 0;
    int n_fail = 0;

    kc85_modbus_ctl #(.WAIT_MAX(WAIT_MAX)) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .OP(op), .SLOT(slot), .WDATA(wdata),
        .BUSY(busy), .DONE(done), .ERR(err), .RDATA(rdata), .A(a), .D_OUT(d_out),
        .D_OE(d_oe), .D_IN(d_in), .IORQ_N(iorq_n), .RD_N(rd_n), .WR_N(wr_n),
        .WAIT_N(wait_n)
    );

    always #5 clk = ~clk;

    // Model: one access described by its T1 cycle, direction and extra-wait count.
    int          cyc = 0;
    bit          m_act = 1'b0;
    int          m_a = 0;
    bit          m_op = 1'b0;
    int          m_n = 0;
    int          stim_n = 0;
    logic [15:0] exp_a = '0;
    logic [7:0]  exp_dout = '0;
    logic [7:0]  exp_rdata = '0;
    int          m_tc;
    bit          m_idle;

    // Offset of the DONE cycle (T1 = offset 1); n >= WAIT_MAX means WAIT never releases in time.
    function automatic int t_done(input int n);
        return (n >= WAIT_MAX) ? 3 + WAIT_MAX : 5 + n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act     = 1'b0;
            exp_a     = '0;
            exp_dout  = '0;
            exp_rdata = '0;
        end else begin
            m_tc = cyc - m_a + 1;
            if (m_act && !m_op && m_tc == t_done(m_n) - 1)
                exp_rdata = (m_n >= WAIT_MAX) ? 8'hFF : d_in;
            m_idle = !m_act || m_tc >= t_done(m_n);
            cyc = cyc + 1;
            if (m_idle && req) begin
                m_act = 1'b1;
                m_a   = cyc;
                m_op  = op;
                m_n   = stim_n;
                exp_a = {slot, 8'h80};
                if (op) exp_dout = wdata;
            end
        end
    end

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_v(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge, compare every output with the model, drive WAIT_N.
    task automatic tick();
        int t, td;
        bit e_busy, e_strb, e_done;
        @(negedge clk);
        t      = cyc - m_a + 1;
        td     = t_done(m_n);
        e_busy = m_act && t >= 1 && t < td;
        e_strb = m_act && t >= 2 && t < td;
        e_done = m_act && t == td;
        check_b("busy", busy, e_busy);
        check_b("done", done, e_done);
        check_b("iorq_n", iorq_n, !e_strb);
        check_b("rd_n", rd_n, !(e_strb && !m_op));
        check_b("wr_n", wr_n, !(e_strb && m_op));
        check_b("d_oe", d_oe, e_busy && m_op);
        check_v("a", a, exp_a);
        check_v("d_out", {8'h00, d_out}, {8'h00, exp_dout});
        check_v("rdata", {8'h00, rdata}, {8'h00, exp_rdata});
        if (e_done) check_b("err", err, m_n >= WAIT_MAX);
        wait_n = !(e_busy && t >= 3 && t < 3 + m_n);
    endtask

    task automatic at_t(input int tt);
        int guard = 0;
        while ((cyc - m_a + 1) != tt && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL at_t: offset %0d never reached", tt);
        end
    endtask

    task automatic access(input logic o, input logic [7:0] s, input logic [7:0] w,
                          input logic [7:0] di, input int n);
        req    = 1'b1;
        op     = o;
        slot   = s;
        wdata  = w;
        d_in   = di;
        stim_n = n;
        tick();
        req = 1'b0;
    endtask

    int starts[$];
    bit prev_busy;

    initial begin
        repeat (3) tick();
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_iorq_n", iorq_n, 1'b1);
        check_v("rst_a", a, 16'h0000);
        check_v("rst_rdata", {8'h00, rdata}, 16'h0000);
        rst = 1'b0;
        tick();

        // Control write, no extra waits
        access(1'b1, 8'h08, 8'h41, 8'h00, 0);
        at_t(1);
        check_v("w_a_t1", a, 16'h0880);
        check_b("w_doe_t1", d_oe, 1'b1);
        check_v("w_dout_t1", {8'h00, d_out}, 16'h0041);
        check_b("w_wrn_t1", wr_n, 1'b1);
        at_t(2);
        check_b("w_wrn_t2", wr_n, 1'b0);
        check_b("w_iorq_t2", iorq_n, 1'b0);
        check_b("w_rdn_t2", rd_n, 1'b1);
        at_t(4);
        check_b("w_wrn_t4", wr_n, 1'b0);
        check_b("w_doe_t4", d_oe, 1'b1);
        at_t(5);
        check_b("w_done", done, 1'b1);
        check_b("w_err", err, 1'b0);
        check_b("w_wrn_t5", wr_n, 1'b1);
        check_b("w_doe_t5", d_oe, 1'b0);
        check_v("w_a_t5", a, 16'h0880);

        // ID read, no extra waits (accepted back-to-back in the DONE cycle)
        access(1'b0, 8'h0C, 8'h00, 8'hF7, 0);
        at_t(2);
        check_b("r_rdn_t2", rd_n, 1'b0);
        check_b("r_doe_t2", d_oe, 1'b0);
        check_v("r_a_t2", a, 16'h0C80);
        at_t(5);
        check_b("r_done", done, 1'b1);
        check_v("r_rdata", {8'h00, rdata}, 16'h00F7);

        // Read with three extra waits
        access(1'b0, 8'h33, 8'h00, 8'h5A, 3);
        at_t(6);
        check_b("rw_rdn_t6", rd_n, 1'b0);
        check_b("rw_done_t6", done, 1'b0);
        at_t(8);
        check_b("rw_done", done, 1'b1);
        check_v("rw_rdata", {8'h00, rdata}, 16'h005A);

        // Longest wait that still completes
        access(1'b0, 8'h5E, 8'h00, 8'h3C, WAIT_MAX - 1);
        at_t(19);
        check_b("rmax_done_t19", done, 1'b0);
        at_t(20);
        check_b("rmax_done", done, 1'b1);
        check_b("rmax_err", err, 1'b0);
        check_v("rmax_rdata", {8'h00, rdata}, 16'h003C);

        // Stuck WAIT on a read
        access(1'b0, 8'h0C, 8'h00, 8'h77, 1000);
        at_t(18);
        check_b("rto_iorq_t18", iorq_n, 1'b0);
        at_t(19);
        check_b("rto_done", done, 1'b1);
        check_b("rto_err", err, 1'b1);
        check_v("rto_rdata", {8'h00, rdata}, 16'h00FF);
        check_b("rto_iorq", iorq_n, 1'b1);

        // Write after the timeout, two extra waits
        access(1'b1, 8'h12, 8'hA5, 8'h00, 2);
        at_t(7);
        check_b("w2_done", done, 1'b1);
        check_v("w2_rdata", {8'h00, rdata}, 16'h00FF);
        check_v("w2_dout", {8'h00, d_out}, 16'h00A5);

        // Stuck WAIT on a write
        access(1'b1, 8'h27, 8'h3E, 8'h00, 1000);
        at_t(19);
        check_b("wto_err", err, 1'b1);
        check_b("wto_wrn", wr_n, 1'b1);
        check_b("wto_doe", d_oe, 1'b0);

        // REQ held high, inputs changing every cycle
        req       = 1'b1;
        stim_n    = 0;
        prev_busy = busy;
        for (int i = 0; i < 23; i++) begin
            op    = i[0];
            slot  = 8'h40 + i[7:0];
            wdata = 8'hC0 ^ i[7:0];
            d_in  = 8'h10 + i[7:0];
            tick();
            if (busy && !prev_busy) starts.push_back(cyc);
            prev_busy = busy;
        end
        req = 1'b0;
        check_v("cont_starts", 16'(starts.size()), 16'd5);
        for (int i = 1; i < starts.size(); i++)
            check_v("cont_spacing", 16'(starts[i] - starts[i-1]), 16'd5);
        repeat (8) tick();

        // Reset during T2 of a write
        access(1'b1, 8'h21, 8'h99, 8'h00, 0);
        at_t(2);
        check_b("rs_wrn_t2", wr_n, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_b("rs_wrn", wr_n, 1'b1);
        check_b("rs_iorq", iorq_n, 1'b1);
        check_b("rs_doe", d_oe, 1'b0);
        check_v("rs_a", a, 16'h0000);
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        check_b("rs_no_done", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
